tl_ul_mem_responder: RTL and testbench
======================================

Name: tl_ul_mem_responder

Overview:
- TileLink-UL responder (slave end) for the single-beat request stream that the fragmenter emits toward memory-mapped devices.
- Accepts one A-channel request (Get / PutFullData / PutPartialData) and performs it on a simple fixed-latency SRAM-style port.
- Returns a D-channel AccessAck or AccessAckData that echoes the request's source and size.
- Sits between the fragmenter's downstream port and a local RAM or register bank.

Parameters:
- ADDR_W, 26, A-channel byte address width
- DATA_W, 32, beat data width; must be 32 (mask is 4 bits)
- SOURCE_W, 3, source ID width
- SIZE_W, 3, size field width (log2 bytes)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  A request valid
- a_ready  out  1  responder can accept A
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_param  in  3  ignored
- a_size  in  SIZE_W  log2 transfer bytes
- a_source  in  SOURCE_W  requester ID
- a_address  in  ADDR_W  byte address
- a_mask  in  4  byte lanes
- a_data  in  DATA_W  write data
- d_valid  out  1  D response valid
- d_ready  in  1  D response accepted
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  SIZE_W  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_data  out  DATA_W  read data; 0 for writes and errors
- d_error  out  1  denied/error response
- mem_req  out  1  one-cycle memory strobe
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  ADDR_W-2  word address (a_address[ADDR_W-1:2])
- mem_wmask  out  4  byte write enables
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_req

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values: state=IDLE; a_ready=0 while reset is high, then 1; d_valid=0, mem_req=0, mem_we=0; all d_* and mem_* data/addr fields=0.
- Reset mid-operation: any in-flight request is dropped and no D response is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: a_ready=1. On a_valid&a_ready, latch opcode, size, source, address, mask and data into a request register, then go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_req=1 unless the latched request is flagged as an error.
  - mem_we=1 for Put opcodes.
  - mem_wmask: a_mask for PutPartial; for PutFull, a_mask is used as given (the fragmenter guarantees it is correct).
  - Next state is RESP.
- RESP entry: d_data captures mem_rdata for a successful Get, otherwise 0.
- RESP:
  - d_valid=1; d_opcode=1 for Get, else 0.
  - All d_* fields stay stable until d_ready.
  - On d_valid&d_ready, go to IDLE.
- a_ready=0 in both ACCESS and RESP. At most one request is outstanding.
- Latency: A fire in cycle N → mem_req in N+1 → d_valid in N+2. Minimum 3 cycles per transaction when d_ready is held at 1.
- D backpressure: d_ready low holds RESP indefinitely. mem_rdata is not resampled while waiting.
- d_param=0 always. No corrupt/denied distinction: d_error covers both.

Optional Feature:
- Macro: TL_RESP_ERR_CHECK_EN.
- Defined: at A fire the request is flagged as an error if any of these hold:
  - opcode not in {0,1,4};
  - a_size>2;
  - address misaligned for its size (a_address & ((1<<a_size)-1) != 0).
- Error handling: the flagged request causes no mem_req. The response has d_error=1 and d_data=0. d_opcode=1 if the opcode was Get, else 0. Latency is unchanged.
- Undefined: no checking. d_error is tied 0. Unsupported opcodes are performed as Get and return AccessAckData.

Test Plan:
- Reset held 2 cycles with a_valid=1 → a_ready=0, d_valid=0 and mem_req=0 throughout; a_ready=1 in the first cycle after release.
- PutFull at addr 0x0000104, mask 0xF, data 0xDEADBEEF, source 5, size 2, d_ready=1 → mem_req one cycle later with mem_we=1, mem_addr=0x41, wmask=0xF; next cycle d_valid with d_opcode=0, d_source=5, d_size=2, d_error=0.
- Get from the same address with mem_rdata=0xDEADBEEF → d_opcode=1 and d_data=0xDEADBEEF two cycles after A fire.
- PutPartial with mask 0x4, data 0x00AB0000, then d_ready held low 5 cycles → d_valid stays 1 with stable fields and a_ready stays 0; a new a_valid is not accepted until the cycle after d_ready.
- With TL_RESP_ERR_CHECK_EN: Get, size 2, addr 0x2 → no mem_req, d_error=1, d_data=0, d_opcode=1. Opcode 6 → no mem_req, d_error=1, d_opcode=0.
- Back-to-back Gets with d_ready=1 → A fires every 3rd cycle; d_source order matches A order.

Source files
------------

// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL single-beat responder bridging A/D channels onto a fixed-latency SRAM-style port.
// Latency: A fire in cycle N, mem_req in N+1, d_valid in N+2; one request outstanding (3 cycles min per txn).
// Backpressure: a_ready low outside IDLE; d_ready low holds the response and its fields stable indefinitely.
// Optional build macro TL_RESP_ERR_CHECK_EN: flags bad opcode/size/alignment as d_error with no memory access.
module tl_ul_mem_responder #(
    parameter int ADDR_W   = 26,
    parameter int DATA_W   = 32,
    parameter int SOURCE_W = 3,
    parameter int SIZE_W   = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [DATA_W-1:0]   a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic [DATA_W-1:0]   d_data,
    output logic                d_error,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [3:0]          mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_nx;
    logic [2:0]          req_opcode;
    logic [SIZE_W-1:0]   req_size;
    logic [SOURCE_W-1:0] req_source;
    logic [ADDR_W-3:0]   req_addr;
    logic [3:0]          req_mask;
    logic [DATA_W-1:0]   req_data;
    logic                req_err;
    logic                resp_first;
    logic [DATA_W-1:0]   d_data_q;
    logic                a_fire;
    logic                req_is_put;
    logic                req_is_get;
    logic                unused_ok;

    assign unused_ok  = ^{a_param, a_address[1:0]};
    assign a_ready    = (state == IDLE) && !reset;
    assign a_fire     = a_valid && a_ready;
    assign req_is_put = (req_opcode == 3'd0) || (req_opcode == 3'd1);

`ifdef TL_RESP_ERR_CHECK_EN
    logic       a_err;
    logic [1:0] align_mask;

    // Classify the incoming request: unsupported opcode, oversize, or misaligned.
    always_comb begin
        align_mask = 2'b11;
        if (a_size == SIZE_W'(0)) align_mask = 2'b00;
        else if (a_size == SIZE_W'(1)) align_mask = 2'b01;
        a_err = !((a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4))
                || (a_size > SIZE_W'(2))
                || ((a_address[1:0] & align_mask) != 2'b00);
    end

    // Error flag travels with the latched request.
    always_ff @(posedge clock) begin
        if (reset)       req_err <= 1'b0;
        else if (a_fire) req_err <= a_err;
    end

    assign req_is_get = (req_opcode == 3'd4);
    assign d_error    = req_err;
`else
    // Without checking, anything that is not a Put is carried out as a Get.
    assign req_err    = 1'b0;
    assign req_is_get = !req_is_put;
    assign d_error    = 1'b0;
`endif

    // State register; reset drops any in-flight request.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: IDLE -> ACCESS on A fire, ACCESS lasts one cycle, RESP until D fire.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (a_fire) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    if (d_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request register loads only in IDLE, so D fields stay stable through RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_opcode <= '0;
            req_size   <= '0;
            req_source <= '0;
            req_addr   <= '0;
            req_mask   <= '0;
            req_data   <= '0;
        end else if (a_fire) begin
            req_opcode <= a_opcode;
            req_size   <= a_size;
            req_source <= a_source;
            req_addr   <= a_address[ADDR_W-1:2];
            req_mask   <= a_mask;
            req_data   <= a_data;
        end
    end

    // Read data arrives in the first RESP cycle; hold it so a stalled response never resamples.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_first <= 1'b0;
            d_data_q   <= '0;
        end else begin
            resp_first <= (state == ACCESS);
            if (resp_first) d_data_q <= d_data;
        end
    end

    // D-channel outputs; data is zero for writes, errors and outside RESP.
    always_comb begin
        d_data = '0;
        if (state == RESP) begin
            if (!resp_first)                   d_data = d_data_q;
            else if (req_is_get && !req_err)   d_data = mem_rdata;
        end
    end

    assign d_valid   = (state == RESP);
    assign d_opcode  = {2'b00, req_is_get};
    assign d_param   = 2'b00;
    assign d_size    = req_size;
    assign d_source  = req_source;

    assign mem_req   = (state == ACCESS) && !req_err;
    assign mem_we    = mem_req && req_is_put;
    assign mem_addr  = req_addr;
    assign mem_wmask = req_is_put ? req_mask : 4'h0;
    assign mem_wdata = req_data;

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Self-checking bench: randomized A requests checked against a reference memory model.
// Latency checked per transaction (mem strobe one cycle after fire, response the next).
// Backpressure exercised by holding d_ready low while offering new A requests.
module tb_tl_ul_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, d_valid, d_ready, d_error;
    logic [2:0]  a_opcode, a_param, a_size, a_source, d_opcode, d_size, d_source;
    logic [25:0] a_address;
    logic [3:0]  a_mask, mem_wmask;
    logic [31:0] a_data, d_data, mem_wdata, mem_rdata;
    logic [1:0]  d_param;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fire_cyc;
    int prev_fire;

    logic [31:0] dev_mem [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 clock = ~clock;

    tl_ul_mem_responder dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_data(d_data), .d_error(d_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous SRAM: read data valid the cycle after the strobe, noise otherwise.
    always @(posedge clock) begin
        if (mem_req && mem_we) dev_mem[mem_addr[7:0]] <= merge(dev_mem[mem_addr[7:0]], mem_wdata, mem_wmask);
        if (mem_req && !mem_we) mem_rdata <= dev_mem[mem_addr[7:0]];
        else                    mem_rdata <= $urandom;
    end

    task automatic scramble_a();
        a_opcode = 3'($urandom); a_param = 3'($urandom); a_size = 3'($urandom);
        a_source = 3'($urandom); a_address = 26'($urandom); a_mask = 4'($urandom);
        a_data = $urandom;
    endtask

    // One full transaction with inline checks; hold = cycles d_ready is kept low.
    task automatic do_txn(input logic [2:0] op, input logic [25:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input logic [2:0] src, input logic [2:0] size,
                          input int hold);
        logic        exp_err, exp_put, exp_dop;
        logic [31:0] exp_data;
        int          k;
        k = int'(addr[9:2]);
`ifdef TL_RESP_ERR_CHECK_EN
        exp_err = !(op == 0 || op == 1 || op == 4) || size > 2 || (int'(addr) % (1 << size)) != 0;
        exp_dop = (op == 4);
`else
        exp_err = 1'b0;
        exp_dop = !(op == 0 || op == 1);
`endif
        exp_put  = !exp_err && (op == 0 || op == 1);
        exp_data = (!exp_err && !exp_put) ? ref_mem[k] : 32'h0;
        if (exp_put) ref_mem[k] = merge(ref_mem[k], data, mask);

        @(negedge clock);
        a_valid = 1'b1; a_opcode = op; a_param = 3'($urandom); a_size = size;
        a_source = src; a_address = addr; a_mask = mask; a_data = data; d_ready = 1'b0;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL accept: a_ready=%b want 1", a_ready); end
        prev_fire = fire_cyc; fire_cyc = cyc;

        @(negedge clock);
        a_valid = 1'b0; scramble_a();
        total++; if (mem_req !== !exp_err) begin bad++; $display("FAIL mem_req: got %b want %b", mem_req, !exp_err); end
        total++; if (mem_we !== exp_put) begin bad++; $display("FAIL mem_we: got %b want %b", mem_we, exp_put); end
        total++; if (a_ready !== 1'b0 || d_valid !== 1'b0) begin bad++; $display("FAIL access_hs: a_ready=%b d_valid=%b want 0 0", a_ready, d_valid); end
        if (!exp_err) begin
            total++; if (mem_addr !== addr[25:2]) begin bad++; $display("FAIL mem_addr: got %h want %h", mem_addr, addr[25:2]); end
        end
        if (exp_put) begin
            total++; if (mem_wmask !== mask || mem_wdata !== data) begin bad++; $display("FAIL mem_wr: got %h/%h want %h/%h", mem_wmask, mem_wdata, mask, data); end
        end
        d_ready = (hold == 0);

        @(negedge clock);
        total++; if (d_valid !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL resp_vld: d_valid=%b mem_req=%b want 1 0", d_valid, mem_req); end
        total++; if (d_opcode !== {2'b00, exp_dop} || d_error !== exp_err || d_param !== 2'b00) begin bad++; $display("FAIL resp_op: op=%0d err=%b param=%0d want %0d %b 0", d_opcode, d_error, d_param, exp_dop, exp_err); end
        total++; if (d_source !== src || d_size !== size) begin bad++; $display("FAIL resp_id: src=%0d size=%0d want %0d %0d", d_source, d_size, src, size); end
        total++; if (d_data !== exp_data) begin bad++; $display("FAIL resp_data: got %h want %h", d_data, exp_data); end

        for (int i = 0; i < hold; i++) begin
            a_valid = 1'b1;
            @(negedge clock);
            total++;
            if (d_valid !== 1'b1 || a_ready !== 1'b0 || d_data !== exp_data || d_source !== src || d_opcode !== {2'b00, exp_dop}) begin
                bad++; $display("FAIL hold%0d: d_valid=%b a_ready=%b data=%h src=%0d want 1 0 %h %0d", i, d_valid, a_ready, d_data, d_source, exp_data, src);
            end
        end
        a_valid = 1'b0; d_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; d_ready = 1'b1;
        a_valid = 1'b1; a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd2; a_source = 3'd5;
        a_address = 26'h104; a_mask = 4'hF; a_data = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            total++; if (a_ready !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL reset_hs: a_ready=%b d_valid=%b mem_req=%b want 0 0 0", a_ready, d_valid, mem_req); end
            total++; if (d_data !== 32'h0 || mem_addr !== 24'h0 || mem_wmask !== 4'h0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_dat: d_data=%h mem_addr=%h wmask=%h we=%b want 0", d_data, mem_addr, mem_wmask, mem_we); end
        end
        reset = 1'b0; a_valid = 1'b0;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_rel: a_ready=%b want 1", a_ready); end
    endtask

    task automatic test_basic();
        do_txn(3'd0, 26'h104, 4'hF, 32'hDEADBEEF, 3'd5, 3'd2, 0);
        do_txn(3'd4, 26'h104, 4'hF, 32'h0, 3'd3, 3'd2, 0);
    endtask

    task automatic test_partial_hold();
        do_txn(3'd1, 26'h104, 4'h4, 32'h00AB0000, 3'd2, 3'd2, 5);
        do_txn(3'd4, 26'h104, 4'hF, 32'h0, 3'd1, 3'd2, 3);
    endtask

    task automatic test_errors();
        do_txn(3'd4, 26'h2, 4'hF, 32'h0, 3'd4, 3'd2, 0);
        do_txn(3'd6, 26'h8, 4'hF, 32'h12345678, 3'd6, 3'd2, 0);
        do_txn(3'd0, 26'h10, 4'hF, 32'hCAFEF00D, 3'd7, 3'd3, 0);
        do_txn(3'd4, 26'h10, 4'hF, 32'h0, 3'd0, 3'd2, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_source = 3'd2; a_address = 26'h104;
        @(negedge clock);
        a_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++; if (d_valid !== 1'b0 || a_ready !== 1'b1) begin bad++; $display("FAIL reset_mid%0d: d_valid=%b a_ready=%b want 0 1", i, d_valid, a_ready); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op, size;
        logic [25:0] addr;
        int          r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 8) ? 3'd4 : 3'($urandom);
            addr = 26'({$urandom_range(0, 7), 2'b00});
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom);
            size = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            do_txn(op, addr, 4'($urandom), $urandom, 3'($urandom), size, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            do_txn(3'd4, 26'({$urandom_range(0, 7), 2'b00}), 4'hF, 32'h0, 3'(n), 3'd2, 0);
            if (n > 0) begin
                total++; if (fire_cyc - prev_fire !== 3) begin bad++; $display("FAIL b2b_gap: got %0d want 3", fire_cyc - prev_fire); end
            end
        end
    endtask

    initial begin
        fire_cyc = 0; prev_fire = 0; mem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) begin dev_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        test_reset();
        test_basic();
        test_partial_hold();
        test_errors();
        test_reset_mid();
        test_random();
        test_back_to_back();
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
